// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the MIPS16 data-memory responder.
// State encodings, opcode constants and default bus widths.
package dmem_responder_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 16;
    localparam int CNT_W      = 4;
    localparam int LAT_MAX    = 15;

    // Opcodes the CPU decodes into req_write
    localparam logic [3:0] OP_LW = 4'b1000;
    localparam logic [3:0] OP_SW = 4'b1001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_responder_if.sv
// Valid/ready request/response bus between the MEM stage and data memory.
// The master is the pipeline; the slave is the responder.
interface dmem_responder_if
    import dmem_responder_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_write;
    logic              rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_write, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_write, rsp_err
    );

endinterface

// File: rtl/dmem_array.sv
// Word-addressed data array: asynchronous read, negedge write with enable.
// Contents are never cleared by reset.
module dmem_array #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1024,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(negedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one in-order transaction at a time with a fixed
// access latency; flags misaligned and out-of-range word accesses.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic clock,
    input  logic reset,
    dmem_responder_if.slave bus
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int FULL_W = ADDR_W - 2;
    localparam bit ZERO_LAT = (LATENCY == 0);
    localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LATENCY);
    localparam logic [FULL_W:0] DEPTH_C = (FULL_W+1)'(DEPTH);

    generate
        if (LATENCY < 0 || LATENCY > LAT_MAX) begin : g_lat_chk
            $error("dmem_responder: LATENCY must be 0..15");
        end
    endgenerate

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [FULL_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_write_q, rsp_write_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    logic              req_ready;
    logic              accept;
    logic [FULL_W-1:0] req_idx;
    logic              req_err;
    logic              op_wr;
    logic [FULL_W-1:0] op_idx;
    logic [DATA_W-1:0] op_wdata;
    logic              op_err;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic              take;
    logic              enter;
    logic              clear;

    assign req_ready = (state_q == S_IDLE) ||
                       (state_q == S_RESP && bus.rsp_ready);
    assign accept    = bus.req_valid && req_ready;

    assign req_idx = bus.req_addr[ADDR_W-1:2];
    assign req_err = (bus.req_addr[1:0] != 2'b00) ||
                     ({1'b0, req_idx} >= DEPTH_C);

    // With no wait cycles the array is accessed on the accepting edge,
    // before the latched copy exists, so use the live request instead.
    assign op_wr    = ZERO_LAT ? bus.req_write : wr_q;
    assign op_idx   = ZERO_LAT ? req_idx       : idx_q;
    assign op_wdata = ZERO_LAT ? bus.req_wdata : wdata_q;
    assign op_err   = ZERO_LAT ? req_err       : err_q;

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clock (clock),
        .we    (mem_we),
        .addr  (op_idx[IDX_W-1:0]),
        .wdata (op_wdata),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        mem_we      = 1'b0;
        take        = 1'b0;
        enter       = 1'b0;
        clear       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                take = accept;
            end
            S_BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= 4'd1) begin
                    state_d = S_RESP;
                    enter   = 1'b1;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    clear   = 1'b1;
                    take    = accept;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (take) begin
            wr_d    = bus.req_write;
            idx_d   = req_idx;
            wdata_d = bus.req_wdata;
            err_d   = req_err;
            cnt_d   = LAT_C;
            state_d = ZERO_LAT ? S_RESP : S_BUSY;
            enter   = ZERO_LAT;
        end

        if (clear) begin
            rsp_valid_d = 1'b0;
            rsp_write_d = 1'b0;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = '0;
        end

        // Stores commit only here, so a reset while waiting drops them
        if (enter) begin
            mem_we      = op_wr && !op_err;
            rsp_valid_d = 1'b1;
            rsp_write_d = op_wr;
            rsp_err_d   = op_err;
            rsp_rdata_d = (op_wr || op_err) ? '0 : mem_rdata;
        end
    end

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_write = rsp_write_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: LATENCY=2 and LATENCY=0 instances,
// table-driven transactions with in-order scoreboards.
module tb_dmem_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    dmem_responder_if #(.DATA_W(16), .ADDR_W(16)) bus2 ();
    dmem_responder_if #(.DATA_W(16), .ADDR_W(16)) bus0 ();

    dmem_responder #(
        .DATA_W(16), .ADDR_W(16), .DEPTH(1024), .LATENCY(2)
    ) u_dut (
        .clock(clk), .reset(rst), .bus(bus2)
    );

    dmem_responder #(
        .DATA_W(16), .ADDR_W(16), .DEPTH(1024), .LATENCY(0)
    ) u_dut0 (
        .clock(clk), .reset(rst), .bus(bus0)
    );

    typedef struct packed {
        logic        wr;
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        exp_t        exp;
    } vec_t;

    exp_t q2[$];
    exp_t q0[$];
    vec_t vt[12];
    vec_t v0[8];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(logic wr, logic [15:0] addr,
                                logic [15:0] wdata, logic ewr,
                                logic [15:0] erd, logic eerr);
        vec_t v;
        v.wr        = wr;
        v.addr      = addr;
        v.wdata     = wdata;
        v.exp.wr    = ewr;
        v.exp.rdata = erd;
        v.exp.err   = eerr;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        exp_t e;
        if (!rst && bus2.rsp_valid && bus2.rsp_ready) begin
            if (q2.size() == 0) begin
                chk("sb2_empty", 32'd0, 32'd1);
            end else begin
                e = q2.pop_front();
                chk("sb2_write", bus2.rsp_write, e.wr);
                chk("sb2_rdata", bus2.rsp_rdata, e.rdata);
                chk("sb2_err", bus2.rsp_err, e.err);
            end
        end
    end

    always @(posedge clk) begin
        exp_t e;
        if (!rst && bus0.rsp_valid && bus0.rsp_ready) begin
            if (q0.size() == 0) begin
                chk("sb0_empty", 32'd0, 32'd1);
            end else begin
                e = q0.pop_front();
                chk("sb0_write", bus0.rsp_write, e.wr);
                chk("sb0_rdata", bus0.rsp_rdata, e.rdata);
                chk("sb0_err", bus0.rsp_err, e.err);
            end
        end
    end

    task automatic run_vec(vec_t v);
        int n;
        n = 0;
        while (!bus2.req_ready && n < 20) begin
            tick();
            n++;
        end
        chk("ready_wait", 32'(n < 20), 32'd1);
        bus2.req_valid = 1'b1;
        bus2.req_write = v.wr;
        bus2.req_addr  = v.addr;
        bus2.req_wdata = v.wdata;
        q2.push_back(v.exp);
        tick();
        bus2.req_valid = 1'b0;
        n = 0;
        while (!bus2.rsp_valid && n < 20) begin
            tick();
            n++;
        end
        chk("latency", 32'(n), 32'd2);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus2.req_valid = 1'b0;
        bus2.req_write = 1'b0;
        bus2.req_addr  = '0;
        bus2.req_wdata = '0;
        bus2.rsp_ready = 1'b1;
        bus0.req_valid = 1'b0;
        bus0.req_write = 1'b0;
        bus0.req_addr  = '0;
        bus0.req_wdata = '0;
        bus0.rsp_ready = 1'b1;

        u_dut.u_array.mem[0]  = 16'd5;
        u_dut.u_array.mem[1]  = 16'd7;
        u_dut0.u_array.mem[0] = 16'd5;
        u_dut0.u_array.mem[1] = 16'd7;

        vt[0]  = mk(1'b0, 16'h0000, 16'h0000, 1'b0, 16'd5,    1'b0);
        vt[1]  = mk(1'b0, 16'h0004, 16'h0000, 1'b0, 16'd7,    1'b0);
        vt[2]  = mk(1'b1, 16'h0000, 16'h0007, 1'b1, 16'd0,    1'b0);
        vt[3]  = mk(1'b0, 16'h0000, 16'h0000, 1'b0, 16'd7,    1'b0);
        vt[4]  = mk(1'b0, 16'h0002, 16'h0000, 1'b0, 16'd0,    1'b1);
        vt[5]  = mk(1'b1, 16'h1000, 16'hDEAD, 1'b1, 16'd0,    1'b1);
        vt[6]  = mk(1'b0, 16'h0000, 16'h0000, 1'b0, 16'd7,    1'b0);
        vt[7]  = mk(1'b1, 16'h0FFC, 16'h1234, 1'b1, 16'd0,    1'b0);
        vt[8]  = mk(1'b0, 16'h0FFC, 16'h0000, 1'b0, 16'h1234, 1'b0);
        vt[9]  = mk(1'b0, 16'hFFFC, 16'h0000, 1'b0, 16'd0,    1'b1);
        vt[10] = mk(1'b1, 16'h0005, 16'h5555, 1'b1, 16'd0,    1'b1);
        vt[11] = mk(1'b0, 16'h0004, 16'h0000, 1'b0, 16'd7,    1'b0);

        v0[0] = mk(1'b1, 16'h0008, 16'd10,   1'b1, 16'd0,  1'b0);
        v0[1] = mk(1'b0, 16'h0008, 16'h0000, 1'b0, 16'd10, 1'b0);
        v0[2] = mk(1'b0, 16'h0000, 16'h0000, 1'b0, 16'd5,  1'b0);
        v0[3] = mk(1'b1, 16'h0003, 16'h0001, 1'b1, 16'd0,  1'b1);
        v0[4] = mk(1'b0, 16'h0004, 16'h0000, 1'b0, 16'd7,  1'b0);
        v0[5] = mk(1'b0, 16'h1000, 16'h0000, 1'b0, 16'd0,  1'b1);
        v0[6] = mk(1'b1, 16'h0000, 16'd9,    1'b1, 16'd0,  1'b0);
        v0[7] = mk(1'b0, 16'h0000, 16'h0000, 1'b0, 16'd9,  1'b0);

        tick();
        tick();
        chk("rst_valid", bus2.rsp_valid, 1'b0);
        chk("rst_rdata", bus2.rsp_rdata, 16'd0);
        chk("rst_write", bus2.rsp_write, 1'b0);
        chk("rst_err", bus2.rsp_err, 1'b0);
        rst = 1'b0;
        chk("rst_ready", bus2.req_ready, 1'b1);

        for (int i = 0; i < 12; i++) begin
            run_vec(vt[i]);
        end
        tick();
        chk("idle_valid", bus2.rsp_valid, 1'b0);

        // Backpressure: response must hold while a stray store waits
        bus2.rsp_ready = 1'b0;
        run_vec(mk(1'b0, 16'h0004, 16'h0000, 1'b0, 16'd7, 1'b0));
        bus2.req_valid = 1'b1;
        bus2.req_write = 1'b1;
        bus2.req_addr  = 16'h0000;
        bus2.req_wdata = 16'hFFFF;
        for (int i = 0; i < 4; i++) begin
            chk("bp_valid", bus2.rsp_valid, 1'b1);
            chk("bp_rdata", bus2.rsp_rdata, 16'd7);
            chk("bp_err", bus2.rsp_err, 1'b0);
            chk("bp_ready", bus2.req_ready, 1'b0);
            tick();
        end
        bus2.req_valid = 1'b0;
        bus2.rsp_ready = 1'b1;
        tick();
        chk("bp_done_valid", bus2.rsp_valid, 1'b0);
        chk("bp_done_ready", bus2.req_ready, 1'b1);
        run_vec(mk(1'b0, 16'h0000, 16'h0000, 1'b0, 16'd7, 1'b0));

        // Reset while a store waits in BUSY
        bus2.req_valid = 1'b1;
        bus2.req_write = 1'b1;
        bus2.req_addr  = 16'h0004;
        bus2.req_wdata = 16'hBEEF;
        tick();
        bus2.req_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("rb_valid", bus2.rsp_valid, 1'b0);
        chk("rb_rdata", bus2.rsp_rdata, 16'd0);
        chk("rb_write", bus2.rsp_write, 1'b0);
        chk("rb_err", bus2.rsp_err, 1'b0);
        tick();
        rst = 1'b0;
        run_vec(mk(1'b0, 16'h0004, 16'h0000, 1'b0, 16'd7, 1'b0));
        tick();

        // Zero latency: one response per cycle with req_valid held
        for (int i = 0; i < 8; i++) begin
            chk("b2b_ready", bus0.req_ready, 1'b1);
            bus0.req_valid = 1'b1;
            bus0.req_write = v0[i].wr;
            bus0.req_addr  = v0[i].addr;
            bus0.req_wdata = v0[i].wdata;
            q0.push_back(v0[i].exp);
            tick();
            chk("b2b_valid", bus0.rsp_valid, 1'b1);
        end
        bus0.req_valid = 1'b0;
        tick();
        chk("b2b_end_valid", bus0.rsp_valid, 1'b0);
        tick();

        chk("sb2_left", 32'(q2.size()), 32'd0);
        chk("sb0_left", 32'(q0.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
